vga_layer_mixer: RTL
====================

# vga_layer_mixer

Pixel-stream compositor downstream of the overlay generators (crosshair and similar) and upstream of the VGA DAC pins. It aligns the timing generator's sync/blank strobes with the overlay and background colour data, selects the overlay pixel where the overlay reports it has drawn, and forces black during blanking. It also keeps a frame counter used for optional overlay blinking.

## Interface
Parameters:
- `DW`, 10, colour channel width
- `BLINK_BIT`, 4, `frame_cnt` bit that gates the overlay when blinking is compiled in

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `pix_ce`  in  1  pixel-clock enable; the pipeline advances only on cycles where it is 1
- `in_hsync`, `in_vsync`  in  1  sync from timing generator, active-low
- `in_blank`  in  1  1 = outside the visible area
- `ovl_r`, `ovl_g`, `ovl_b`  in  DW  overlay colour for current `px`/`py`
- `ovl_printed`  in  1  overlay claims this pixel
- `bg_r`, `bg_g`, `bg_b`  in  DW  background (camera/frame) colour for current pixel
- `out_r`, `out_g`, `out_b`  out  DW  mixed colour to DAC
- `out_hsync`, `out_vsync`, `out_blank`  out  1  delayed sync/blank, aligned with colour
- `frame_cnt`  out  8  completed-frame counter

## Operation
- Two-stage pipeline. Both stages advance only when `pix_ce`=1; when `pix_ce`=0 every register holds.
- Stage 1 registers all inputs unchanged: syncs, blank, overlay colour, `ovl_printed`, background colour.
- Stage 2 computes the outputs:
  - if stage-1 blank=1: `out_r/g/b` = 0;
  - else if stage-1 `ovl_printed`=1 and overlay is enabled: output = overlay colour, all three channels taken together;
  - else: output = background colour.
  - Syncs and blank pass through stage 2 unchanged.
- Overlay selection uses `ovl_printed` only. Individual channel values are never compared against a null sentinel.
- Frame counter:
  - a vsync falling edge is detected when `in_vsync`=0 and the stage-1 vsync register=1, on a `pix_ce` cycle;
  - `frame_cnt` increments on that same cycle;
  - wraps 255→0 silently.
- Overlay enable: always 1, except as described under Configuration.
- Width rule: no arithmetic on colour. Channels are muxed bit-for-bit at DW.

## Timing
- Latency: 2 `pix_ce` strobes from inputs to outputs, identical for colour, sync and blank. Alignment is therefore exact.
- Reset values, held until the first two `pix_ce` strobes after reset deassertion have flushed the pipeline:
  - `out_r/g/b` = 0
  - `out_hsync` = 1, `out_vsync` = 1
  - `out_blank` = 1
  - `frame_cnt` = 0
  - all stage-1 registers take the same idle values (syncs 1, blank 1, colours 0, printed 0)
- Reset mid-frame: the pipeline is flushed to idle values in the reset cycle. The first post-reset falling vsync counts as frame 1.
- `rst` overrides `pix_ce`: reset takes effect even when `pix_ce`=0.
- Simultaneous vsync edge and visible overlay pixel: stage 2 uses the `frame_cnt` register value as it stands in that cycle. The increment becomes visible from the next `pix_ce`.
- `pix_ce` held high continuously is legal: the pipeline runs at full `clk` rate.

## Configuration
- `VGA_MIX_BLINK_EN` defined:
  - overlay enable = `~frame_cnt[BLINK_BIT]`;
  - the overlay is shown for 16 frames, then hidden for 16 frames, with the default `BLINK_BIT`;
  - hidden frames output background.
- `VGA_MIX_BLINK_EN` not defined:
  - overlay enable is constant 1;
  - `frame_cnt` still counts and is output.

## Test plan
- Reset then idle, `pix_ce`=1 → outputs stay at reset values: rgb 0, syncs 1, blank 1, `frame_cnt`=0.
- Visible pixel, `ovl_printed`=1, overlay 0x000/0x000/0x3FF, background 0x155 each → exactly 2 strobes later `out` = 0/0/0x3FF. Same pixel with `ovl_printed`=0 → 0x155/0x155/0x155.
- `in_blank`=1 with `ovl_printed`=1 and nonzero colours → rgb 0, `out_blank`=1, after 2 strobes.
- `pix_ce` toggling 1-in-2 with a hsync pulse → `out_hsync` pulse has the same width in strobes and is delayed exactly 2 strobes. Outputs are stable on `pix_ce`=0 cycles.
- 257 vsync falling edges → `frame_cnt` wraps through 255 to 0, then reads 1. With `VGA_MIX_BLINK_EN` defined, the overlay is hidden while `frame_cnt` is 16–31 and visible while it is 0–15 and 32–47.
- Assert `rst` for 1 cycle mid-line with `pix_ce`=0 → next cycle shows reset values and `frame_cnt`=0.

Source files
------------

// File: rtl/vga_layer_mixer.sv
// Two-stage pixel compositor: aligns sync/blank with colour, selects overlay over background, blanks to black.
// Optional overlay blinking is compiled in with `define VGA_MIX_BLINK_EN.
module vga_layer_mixer #(
    parameter int DW        = 10,
    parameter int BLINK_BIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    input  logic          in_hsync,
    input  logic          in_vsync,
    input  logic          in_blank,
    input  logic [DW-1:0] ovl_r,
    input  logic [DW-1:0] ovl_g,
    input  logic [DW-1:0] ovl_b,
    input  logic          ovl_printed,
    input  logic [DW-1:0] bg_r,
    input  logic [DW-1:0] bg_g,
    input  logic [DW-1:0] bg_b,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_g,
    output logic [DW-1:0] out_b,
    output logic          out_hsync,
    output logic          out_vsync,
    output logic          out_blank,
    output logic [7:0]    frame_cnt
);

    if ((BLINK_BIT < 0) || (BLINK_BIT > 7)) begin : g_bad_blink_bit
        $error("BLINK_BIT must select a bit of the 8-bit frame counter");
    end

    logic          s1_hsync_r;
    logic          s1_vsync_r;
    logic          s1_blank_r;
    logic          s1_printed_r;
    logic [DW-1:0] s1_ovl_r_r;
    logic [DW-1:0] s1_ovl_g_r;
    logic [DW-1:0] s1_ovl_b_r;
    logic [DW-1:0] s1_bg_r_r;
    logic [DW-1:0] s1_bg_g_r;
    logic [DW-1:0] s1_bg_b_r;

    logic          vsync_fall_s;
    logic          ovl_en_s;
    logic [DW-1:0] mix_r_s;
    logic [DW-1:0] mix_g_s;
    logic [DW-1:0] mix_b_s;

    // Overlay gating and vsync falling-edge detection from the current counter / stage-1 state
    always_comb begin
        vsync_fall_s = pix_ce & ~in_vsync & s1_vsync_r;
`ifdef VGA_MIX_BLINK_EN
        ovl_en_s = ~frame_cnt[BLINK_BIT];
`else
        ovl_en_s = 1'b1;
`endif
    end

    // Colour select: blanking forces black, otherwise overlay wins as a whole triple
    always_comb begin
        mix_r_s = {DW{1'b0}};
        mix_g_s = {DW{1'b0}};
        mix_b_s = {DW{1'b0}};
        if (s1_blank_r) begin
            mix_r_s = {DW{1'b0}};
            mix_g_s = {DW{1'b0}};
            mix_b_s = {DW{1'b0}};
        end else if (s1_printed_r && ovl_en_s) begin
            mix_r_s = s1_ovl_r_r;
            mix_g_s = s1_ovl_g_r;
            mix_b_s = s1_ovl_b_r;
        end else begin
            mix_r_s = s1_bg_r_r;
            mix_g_s = s1_bg_g_r;
            mix_b_s = s1_bg_b_r;
        end
    end

    // Stage 1: capture every input unchanged on a pixel strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hsync_r   <= 1'b1;
            s1_vsync_r   <= 1'b1;
            s1_blank_r   <= 1'b1;
            s1_printed_r <= 1'b0;
            s1_ovl_r_r   <= {DW{1'b0}};
            s1_ovl_g_r   <= {DW{1'b0}};
            s1_ovl_b_r   <= {DW{1'b0}};
            s1_bg_r_r    <= {DW{1'b0}};
            s1_bg_g_r    <= {DW{1'b0}};
            s1_bg_b_r    <= {DW{1'b0}};
        end else if (pix_ce) begin
            s1_hsync_r   <= in_hsync;
            s1_vsync_r   <= in_vsync;
            s1_blank_r   <= in_blank;
            s1_printed_r <= ovl_printed;
            s1_ovl_r_r   <= ovl_r;
            s1_ovl_g_r   <= ovl_g;
            s1_ovl_b_r   <= ovl_b;
            s1_bg_r_r    <= bg_r;
            s1_bg_g_r    <= bg_g;
            s1_bg_b_r    <= bg_b;
        end else begin
            s1_hsync_r   <= s1_hsync_r;
            s1_vsync_r   <= s1_vsync_r;
            s1_blank_r   <= s1_blank_r;
            s1_printed_r <= s1_printed_r;
            s1_ovl_r_r   <= s1_ovl_r_r;
            s1_ovl_g_r   <= s1_ovl_g_r;
            s1_ovl_b_r   <= s1_ovl_b_r;
            s1_bg_r_r    <= s1_bg_r_r;
            s1_bg_g_r    <= s1_bg_g_r;
            s1_bg_b_r    <= s1_bg_b_r;
        end
    end

    // Stage 2: registered mixed colour with sync/blank delayed by the same amount
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r     <= {DW{1'b0}};
            out_g     <= {DW{1'b0}};
            out_b     <= {DW{1'b0}};
            out_hsync <= 1'b1;
            out_vsync <= 1'b1;
            out_blank <= 1'b1;
        end else if (pix_ce) begin
            out_r     <= mix_r_s;
            out_g     <= mix_g_s;
            out_b     <= mix_b_s;
            out_hsync <= s1_hsync_r;
            out_vsync <= s1_vsync_r;
            out_blank <= s1_blank_r;
        end else begin
            out_r     <= out_r;
            out_g     <= out_g;
            out_b     <= out_b;
            out_hsync <= out_hsync;
            out_vsync <= out_vsync;
            out_blank <= out_blank;
        end
    end

    // Completed-frame counter, wraps silently at 8 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if (vsync_fall_s) begin
            frame_cnt <= frame_cnt + 8'd1;
        end else begin
            frame_cnt <= frame_cnt;
        end
    end

endmodule
